seg7_scan_bcd: RTL and testbench

Parametrised N-digit multiplexed 7-segment driver for the Basys3 display path. It accepts a binary value through a load/busy handshake and converts it to BCD sequentially (shift-add-3). It scans NDIG common-anode digits with per-digit decimal points, optional leading-zero blanking, overflow indication, and PWM brightness. It sits between the application FSMs and the board pins, replacing per-use fixed-pattern digit decoders.

---
 rtl/seg7_scan_bcd_pkg.sv | 48 ++++
 rtl/bin2bcd_seq.sv | 84 ++++++++
 rtl/seg7_scan_bcd.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_bcd.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types, glyph constants and helpers for the scanned
//               7-segment BCD display path.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    // Basys3 active-low glyphs, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7_enc(input bcd_t code);
        case (code)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential shift-add-3 binary to BCD converter, one bit per
//               cycle, with a single-cycle done pulse and overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int VAL_W = 14,
    parameter int NDIG  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [VAL_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd,
    output logic                ovf
);

    localparam int          c_BCD_W = 4 * (NDIG + 1);
    localparam int          c_CNT_W = $clog2(VAL_W + 1);
    localparam logic [63:0] c_MAX   = pow10(NDIG) - 64'd1;

    conv_state_t          r_state;
    logic [VAL_W-1:0]     r_bin;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ovf;
    logic [c_BCD_W-1:0]   w_adj;

    for (genvar i = 0; i < NDIG + 1; i++) begin : g_adj
        assign w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                           : r_bcd[4*i +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin   <= bin;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        // Overflow is judged on the binary value so the nibble
                        // count never has to cover the full input range.
                        r_ovf   <= (64'(bin) > c_MAX);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd <= {w_adj[c_BCD_W-2:0], r_bin[VAL_W-1]};
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(VAL_W - 1)) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == COMMIT);
    assign bcd  = r_bcd[4*NDIG-1:0];
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_bcd.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_bcd
// Description : N-digit multiplexed common-anode 7-segment driver with
//               sequential BCD conversion, blanking, overflow and PWM dimming.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_bcd
    import seg7_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int VAL_W    = 14,
    parameter int SCAN_DIV = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [VAL_W-1:0]  value,
    input  logic [NDIG-1:0]   dp_mask,
    input  logic              blank_lz,
    input  logic [2:0]        bright,
    output logic              busy,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [NDIG-1:0]   an
);

    localparam int c_IDX_W = $clog2(NDIG);
    localparam int c_PRE_W = $clog2(SCAN_DIV);

    logic                 w_busy;
    logic                 w_done;
    logic [4*NDIG-1:0]    w_bcd;
    logic                 w_ovf;

    logic [4*NDIG-1:0]    r_dig;
    logic                 r_ovf;
    logic [c_PRE_W-1:0]   r_pre;
    logic [c_IDX_W-1:0]   r_idx;
    logic [2:0]           r_pwm;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic [NDIG-1:0]      r_an;

    logic [NDIG-1:0]      w_blank;
    bcd_t                 w_sel_code;
    logic                 w_sel_blank;
    logic                 w_sel_dp;
    logic [6:0]           w_seg_pat;
    logic                 w_lit;
    logic [NDIG-1:0]      w_an_sel;

    bin2bcd_seq #(
        .VAL_W (VAL_W),
        .NDIG  (NDIG)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .bin   (value),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd),
        .ovf   (w_ovf)
    );

    // Display registers only change on the converter's done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dig <= '0;
            r_ovf <= 1'b0;
        end else if (w_done) begin
            r_dig <= w_bcd;
            r_ovf <= w_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 3'd1;
            if (r_pre == c_PRE_W'(SCAN_DIV - 1)) begin
                r_pre <= '0;
                r_idx <= (r_idx == c_IDX_W'(NDIG - 1)) ? '0 : r_idx + c_IDX_W'(1);
            end else begin
                r_pre <= r_pre + c_PRE_W'(1);
            end
        end
    end

    // A digit is blank when it and everything above it is zero; digit 0 never is.
    assign w_blank[0] = 1'b0;
    for (genvar i = 1; i < NDIG; i++) begin : g_blank
        assign w_blank[i] = blank_lz && (r_dig[4*NDIG-1:4*i] == '0);
    end

    always_comb begin
        w_sel_code  = '0;
        w_sel_blank = 1'b0;
        w_sel_dp    = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_sel_code  = r_dig[4*i +: 4];
                w_sel_blank = w_blank[i];
                w_sel_dp    = dp_mask[i];
            end
        end
    end

    assign w_seg_pat = r_ovf       ? SEG_DASH  :
                       w_sel_blank ? SEG_BLANK : seg7_enc(w_sel_code);
    assign w_lit     = (bright == 3'd7) || (r_pwm < bright);
    assign w_an_sel  = ~({{(NDIG-1){1'b0}}, 1'b1} << r_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
            r_an  <= '1;
        end else if (w_lit) begin
            r_seg <= w_seg_pat;
            r_dp  <= ~w_sel_dp;
            r_an  <= w_an_sel;
        end else begin
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
            r_an  <= '1;
        end
    end

    assign busy = w_busy;
    assign seg  = r_seg;
    assign dp   = r_dp;
    assign an   = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_bcd
// Description : Scoreboard bench for seg7_scan_bcd with a decimal-arithmetic
//               reference model and randomized loads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_bcd;

    localparam int NDIG     = 4;
    localparam int VAL_W    = 14;
    localparam int SCAN_DIV = 12;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              load     = 1'b0;
    logic [VAL_W-1:0]  value    = '0;
    logic [NDIG-1:0]   dp_mask  = '0;
    logic              blank_lz = 1'b0;
    logic [2:0]        bright   = 3'd7;
    logic              busy;
    logic [6:0]        seg;
    logic              dp;
    logic [NDIG-1:0]   an;

    int tests    = 0;
    int fails    = 0;
    int mon_done = 0;
    bit mon_en   = 1'b1;

    typedef struct packed {
        logic [NDIG*7-1:0] segs;
        logic [NDIG-1:0]   dpm;
    } exp_t;

    exp_t sb_q[$];

    seg7_scan_bcd #(
        .NDIG     (NDIG),
        .VAL_W    (VAL_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .dp_mask  (dp_mask),
        .blank_lz (blank_lz),
        .bright   (bright),
        .busy     (busy),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] ref_glyph(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected glyph per digit slot from decimal arithmetic on the value.
    function automatic logic [NDIG*7-1:0] model(int unsigned v, bit blz);
        logic [NDIG*7-1:0] r;
        int unsigned p;
        int unsigned lim;
        lim = 1;
        for (int i = 0; i < NDIG; i++) lim = lim * 10;
        p = 1;
        for (int i = 0; i < NDIG; i++) begin
            if (v >= lim)                 r[i*7 +: 7] = 7'b0111111;
            else if (blz && i > 0 && v < p) r[i*7 +: 7] = 7'h7F;
            else                          r[i*7 +: 7] = ref_glyph(int'((v / p) % 10));
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Observe one full scan with bright=7 and compare every slot to the expectation.
    task automatic check_display(input logic [NDIG*7-1:0] es, input logic [NDIG-1:0] dpm,
                                 input string tag);
        logic [7:0] obs_seg [NDIG];
        logic [1:0] obs_dp  [NDIG];
        bit         bad     [NDIG];
        int         an_bad;
        int         k;
        an_bad = 0;
        for (int i = 0; i < NDIG; i++) begin
            obs_seg[i] = 8'hFF;
            obs_dp[i]  = 2'b11;
            bad[i]     = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int c = 0; c < NDIG*SCAN_DIV + 2; c++) begin
            if ($countones(~an) != 1) begin
                an_bad++;
            end else begin
                k = 0;
                for (int i = 0; i < NDIG; i++) if (!an[i]) k = i;
                if (!bad[k]) begin
                    obs_seg[k] = {1'b0, seg};
                    obs_dp[k]  = {1'b0, dp};
                    if (seg != es[k*7 +: 7] || dp != ~dpm[k]) bad[k] = 1'b1;
                end
            end
            @(negedge clk);
        end
        chk($sformatf("%s an_onehot_bad_cycles", tag), an_bad, 0);
        for (int i = 0; i < NDIG; i++) begin
            chk($sformatf("%s slot%0d seg", tag, i), obs_seg[i], {1'b0, es[i*7 +: 7]});
            chk($sformatf("%s slot%0d dp", tag, i), obs_dp[i], {1'b0, ~dpm[i]});
        end
    endtask

    // Monitor: measures each conversion and checks the display it leaves behind.
    initial begin : monitor
        int   n;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy && !rst) begin
                n = 0;
                while (busy && n < 200) begin
                    n++;
                    @(negedge clk);
                end
                if (mon_en) begin
                    chk("busy_cycles", n, VAL_W + 1);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_conversion", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check_display(e.segs, e.dpm, "conv");
                    end
                    mon_done++;
                end
            end
        end
    end

    task automatic do_load(input int unsigned v, input bit blz, input logic [NDIG-1:0] dpm,
                           input bit extra);
        exp_t e;
        int   target;
        int   n;
        blank_lz = blz;
        dp_mask  = dpm;
        value    = VAL_W'(v);
        e.segs   = model(v, blz);
        e.dpm    = dpm;
        sb_q.push_back(e);
        target   = mon_done + 1;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        if (extra) begin
            repeat (5) @(negedge clk);
            value = VAL_W'(9999);
            load  = 1'b1;
            @(negedge clk);
            load  = 1'b0;
        end
        n = 0;
        while (mon_done < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("conversion_seen v=%0d", v), mon_done, target);
    endtask

    initial begin : driver
        logic [NDIG-1:0] seq [4];
        int n;
        int lit;
        int exp_lit;
        int unsigned rv;
        logic [2:0] br_tab [4];

        seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
        br_tab[0] = 3'd0; br_tab[1] = 3'd1; br_tab[2] = 3'd4; br_tab[3] = 3'd7;

        repeat (4) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset seg", seg, 7'h7F);
        chk("reset dp", dp, 1);
        chk("reset an", an, 4'hF);
        rst = 1'b0;

        // Scan order and slot dwell time after reset
        n = 0;
        while (an != seq[0] && n < 4*SCAN_DIV + 4) begin
            @(negedge clk);
            n++;
        end
        chk("scan reach 1101", an, seq[0]);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (an == seq[i] && n < 4*SCAN_DIV) begin
                n++;
                @(negedge clk);
            end
            chk($sformatf("scan dwell slot %0d", i + 1), n, SCAN_DIV);
            chk($sformatf("scan next after %0d", i + 1), an, seq[i+1]);
        end
        check_display(model(0, 1'b0), '0, "reset_zeros");

        do_load(1234, 1'b0, 4'b0000, 1'b0);
        do_load(7, 1'b1, 4'b0000, 1'b0);
        do_load(0, 1'b1, 4'b0000, 1'b0);
        do_load(10000, 1'b0, 4'b0100, 1'b0);
        do_load(9999, 1'b1, 4'b1001, 1'b0);
        do_load(4321, 1'b0, 4'b0010, 1'b1);

        // Live blank_lz change on already committed digits
        do_load(42, 1'b0, 4'b0000, 1'b0);
        blank_lz = 1'b1;
        check_display(model(42, 1'b1), '0, "live_blank");

        for (int t = 0; t < 8; t++) begin
            rv = (t % 3 == 0) ? $urandom_range(0, 16383) : $urandom_range(0, 9999);
            if (t == 1) rv = $urandom_range(0, 99);
            do_load(rv, 1'($urandom_range(0, 1)), NDIG'($urandom_range(0, 15)), 1'b0);
        end

        // Reset in the middle of a conversion
        mon_en   = 1'b0;
        blank_lz = 1'b0;
        dp_mask  = '0;
        value    = VAL_W'(5678);
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort busy before rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy after rst", busy, 0);
        check_display(model(0, 1'b0), '0, "abort_zeros");
        n = 0;
        for (int c = 0; c < VAL_W + 5; c++) begin
            if (busy) n++;
            @(negedge clk);
        end
        chk("abort no restart", n, 0);
        check_display(model(0, 1'b0), '0, "abort_no_commit");
        mon_en = 1'b1;

        // Brightness duty over three full PWM periods
        for (int b = 0; b < 4; b++) begin
            bright = br_tab[b];
            repeat (3) @(negedge clk);
            lit = 0;
            for (int c = 0; c < 24; c++) begin
                if (an != 4'hF) lit++;
                @(negedge clk);
            end
            exp_lit = (br_tab[b] == 3'd7) ? 24 : 3 * int'(br_tab[b]);
            chk($sformatf("bright %0d lit cycles", br_tab[b]), lit, exp_lit);
        end
        bright = 3'd7;

        chk("scoreboard drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
